// File: rtl/video_render_sched.sv
// Per-line render controller: launches renderers on each line strobe, arbitrates
// the shared VRAM read port round-robin, and flags completion, overrun and vblank.
module video_render_sched #(
  parameter int V_ACTIVE = 480,
  parameter int NREQ     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            next_frame_i,
  input  logic            next_line_i,
  input  logic            vblank_pulse_i,
  input  logic [NREQ-1:0] ren_en_i,
  input  logic [NREQ-1:0] ren_done_i,
  output logic [NREQ-1:0] ren_start_o,
  output logic            ren_abort_o,
  output logic [8:0]      render_line_o,
  output logic            line_valid_o,
  input  logic [NREQ-1:0] vram_req_i,
  output logic [NREQ-1:0] vram_grant_o,
  input  logic            vram_ack_i,
  output logic            line_done_o,
  output logic            overrun_o,
  output logic            irq_vblank_o,
  input  logic            irq_clr_i
);

  // state  | meaning
  // IDLE   | waiting for a line strobe
  // LAUNCH | start pulse to enabled renderers (and abort after an overrun)
  // RUN    | renderers busy, VRAM arbitration active
  // DONE   | all enabled renderers finished, line_done pulses
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [8:0] V_ACT9 = 9'(V_ACTIVE);
  localparam logic [8:0] LINE_MAX = 9'd511;

  state_t          state_q, state_d;
  logic [8:0]      line_q, line_d;
  logic [NREQ-1:0] en_q, en_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] done_acc;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            abort_q, overrun_q, irq_q;
  logic            new_valid, ovr_evt;
  logic [NREQ-1:0] req_m, pick;
  logic [PW-1:0]   idx, gidx;
  logic            found;

  always_comb begin
    line_d = line_q;
    if (next_frame_i) begin
      line_d = '0;
    end else if (next_line_i && line_q != LINE_MAX) begin
      line_d = line_q + 9'd1;
    end
  end

  assign new_valid = (line_d < V_ACT9);

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    done_d      = done_q;
    done_acc    = done_q | (ren_done_i & en_q);
    ovr_evt     = 1'b0;
    line_done_o = 1'b0;
    ren_start_o = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          line_done_o = 1'b1;
          state_d     = IDLE;
          done_d      = '0;
        end
      end
      LAUNCH: begin
        ren_start_o = en_q;
        ovr_evt     = next_line_i;
        state_d     = (en_q != '0) ? RUN : DONE;
      end
      RUN: begin
        ovr_evt = next_line_i;
        done_d  = done_acc;
        if (done_acc == en_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // A line strobe always relaunches, whether or not the previous line was finished.
    if (next_line_i) begin
      done_d  = '0;
      state_d = IDLE;
      if (new_valid) begin
        state_d = LAUNCH;
        en_d    = ren_en_i;
      end
    end
  end

  always_comb begin
    req_m = vram_req_i & en_q;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_m[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (grant_q != '0) begin
      if (vram_ack_i) begin
        grant_d = '0;
        ptr_d   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end else if ((grant_q & req_m) == '0) begin
        grant_d = '0;
      end
    end else begin
      grant_d = pick;
    end
    if (state_d != RUN) grant_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      en_q      <= '0;
      done_q    <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      en_q    <= en_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      abort_q <= ovr_evt;
      if (ovr_evt) overrun_q <= 1'b1;
      else if (irq_clr_i) overrun_q <= 1'b0;
      if (vblank_pulse_i) irq_q <= 1'b1;
      else if (irq_clr_i) irq_q <= 1'b0;
    end
  end

  assign ren_abort_o   = abort_q;
  assign render_line_o = line_q;
  assign line_valid_o  = (line_q < V_ACT9);
  assign vram_grant_o  = grant_q;
  assign overrun_o     = overrun_q;
  assign irq_vblank_o  = irq_q;

endmodule

// File: tb/tb_video_render_sched.sv
// Directed bench for video_render_sched: line launch, completion, arbitration,
// overrun, line index saturation, vblank interrupt and asynchronous reset.
module tb_video_render_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_frame, next_line, vblank_pulse, vram_ack, irq_clr;
  logic [2:0] ren_en, ren_done, vram_req;
  logic [2:0] ren_start, vram_grant;
  logic       ren_abort, line_valid, line_done, overrun, irq_vblank;
  logic [8:0] render_line;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  logic [2:0] exp_grant_q[$];
  logic [2:0] exp_g;

  video_render_sched #(.V_ACTIVE(480), .NREQ(3)) dut (
    .clk(clk), .rst(rst),
    .next_frame_i(next_frame), .next_line_i(next_line), .vblank_pulse_i(vblank_pulse),
    .ren_en_i(ren_en), .ren_done_i(ren_done), .ren_start_o(ren_start),
    .ren_abort_o(ren_abort), .render_line_o(render_line), .line_valid_o(line_valid),
    .vram_req_i(vram_req), .vram_grant_o(vram_grant), .vram_ack_i(vram_ack),
    .line_done_o(line_done), .overrun_o(overrun), .irq_vblank_o(irq_vblank),
    .irq_clr_i(irq_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(ren_start), 0);
    chk({tag, "_abort"}, 32'(ren_abort), 0);
    chk({tag, "_line"}, 32'(render_line), 0);
    chk({tag, "_grant"}, 32'(vram_grant), 0);
    chk({tag, "_ldone"}, 32'(line_done), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
    chk({tag, "_irq"}, 32'(irq_vblank), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; next_frame = 0; next_line = 0; vblank_pulse = 0; vram_ack = 0;
    irq_clr = 0; ren_en = 0; ren_done = 0; vram_req = 0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // frame start with all renderers, done order 0, 2, 1
    next_frame = 1; next_line = 1; ren_en = 3'b111;
    step();
    next_frame = 0; next_line = 0; ren_en = 0;
    chk("l0_line", 32'(render_line), 0);
    chk("l0_valid", 32'(line_valid), 1);
    chk("l0_start", 32'(ren_start), 3'b111);
    step();
    chk("l0_start_once", 32'(ren_start), 0);
    ren_done = 3'b001; step(); ren_done = 0;
    chk("l0_no_done_a", 32'(line_done), 0);
    ren_done = 3'b100; step(); ren_done = 0;
    chk("l0_no_done_b", 32'(line_done), 0);
    ren_done = 3'b010; step(); ren_done = 0;
    chk("l0_line_done", 32'(line_done), 1);
    step();
    chk("l0_done_once", 32'(line_done), 0);

    // round-robin arbitration with all requests held
    next_line = 1; ren_en = 3'b111;
    step();
    next_line = 0; ren_en = 0;
    step();
    vram_req = 3'b111;
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b001);
    for (int n = 0; n < 4; n++) begin
      int budget = 0;
      while (vram_grant == 3'b000 && budget < 8) begin
        step();
        budget++;
      end
      chk("arb_grant_seen", 32'(vram_grant != 3'b000), 1);
      chk("arb_onehot", 32'($countones(vram_grant)), 1);
      exp_g = exp_grant_q.pop_front();
      chk("arb_order", 32'(vram_grant), 32'(exp_g));
      vram_ack = 1; step(); vram_ack = 0;
      chk("arb_drop", 32'(vram_grant), 0);
    end
    vram_req = 0;
    ren_done = 3'b111; step(); ren_done = 0;
    chk("arb_line_done", 32'(line_done), 1);
    chk("arb_grant_clear", 32'(vram_grant), 0);
    step();

    // no renderers enabled
    vram_req = 3'b111;
    next_line = 1; ren_en = 3'b000;
    step();
    next_line = 0;
    chk("en0_start", 32'(ren_start), 0);
    chk("en0_early_done", 32'(line_done), 0);
    step();
    chk("en0_line_done", 32'(line_done), 1);
    chk("en0_grant", 32'(vram_grant), 0);
    step();
    chk("en0_done_once", 32'(line_done), 0);
    chk("en0_grant_idle", 32'(vram_grant), 0);
    vram_req = 0;

    // overrun: strobe with two of three renderers done
    next_line = 1; ren_en = 3'b111;
    step();
    next_line = 0; ren_en = 0;
    step();
    ren_done = 3'b001; step();
    ren_done = 3'b010; step();
    ren_done = 0;
    next_line = 1; ren_en = 3'b011;
    step();
    next_line = 0; ren_en = 0;
    chk("ovr_abort", 32'(ren_abort), 1);
    chk("ovr_start", 32'(ren_start), 3'b011);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_no_done", 32'(line_done), 0);
    step();
    chk("ovr_abort_once", 32'(ren_abort), 0);
    chk("ovr_no_done2", 32'(line_done), 0);
    irq_clr = 1; step(); irq_clr = 0;
    chk("ovr_clr", 32'(overrun), 0);
    ren_done = 3'b011; step(); ren_done = 0;
    chk("ovr_next_done", 32'(line_done), 1);
    step();

    // line index walk, invalid lines and saturation
    next_frame = 1; next_line = 1; ren_en = 0;
    step();
    next_frame = 0; next_line = 0;
    chk("walk_line0", 32'(render_line), 0);
    step(); step();
    for (int n = 1; n <= 480; n++) begin
      next_line = 1; ren_en = (n == 480) ? 3'b111 : 3'b000;
      step();
      next_line = 0; ren_en = 0;
      if (n == 479) begin
        chk("walk_479", 32'(render_line), 479);
        chk("walk_479_valid", 32'(line_valid), 1);
      end
      if (n == 480) begin
        chk("walk_480", 32'(render_line), 480);
        chk("walk_480_valid", 32'(line_valid), 0);
        chk("walk_480_start", 32'(ren_start), 0);
      end
      step(); step();
      if (n == 480) begin
        chk("walk_480_nodone", 32'(line_done), 0);
        chk("walk_480_nostart", 32'(ren_start), 0);
      end
    end
    for (int k = 1; k <= 43; k++) begin
      next_line = 1;
      step();
      next_line = 0;
      if (k == 30 || k == 31 || k == 32 || k == 43)
        chk("sat_line", 32'(render_line), (480 + k > 511) ? 511 : 480 + k);
    end
    next_frame = 1; next_line = 1; ren_en = 0;
    step();
    next_frame = 0; next_line = 0;
    chk("frame_wrap", 32'(render_line), 0);
    chk("frame_wrap_valid", 32'(line_valid), 1);
    step(); step();

    // vblank interrupt: set beats clear
    vblank_pulse = 1; irq_clr = 1;
    step();
    vblank_pulse = 0; irq_clr = 0;
    chk("irq_set_wins", 32'(irq_vblank), 1);
    step();
    chk("irq_sticky", 32'(irq_vblank), 1);
    irq_clr = 1; step(); irq_clr = 0;
    chk("irq_clr", 32'(irq_vblank), 0);

    // asynchronous reset in the middle of a line
    next_line = 1; ren_en = 3'b111;
    step();
    next_line = 0; ren_en = 0;
    chk("rst_pre_start", 32'(ren_start), 3'b111);
    step();
    vram_req = 3'b111; vblank_pulse = 1;
    step();
    vblank_pulse = 0;
    chk("rst_pre_grant", 32'(vram_grant != 3'b000), 1);
    chk("rst_pre_irq", 32'(irq_vblank), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    step();
    chk_all_zero("rst_held");
    vram_req = 0;
    rst = 1'b0;
    step();
    chk("rst_after_line", 32'(render_line), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
